// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Digit width, FSM state encoding and the DIGITS sizing function.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // Decimal digit count of the largest WIDTH-bit unsigned value.
  function automatic int min_digits(input int width);
    longint unsigned m;
    int              n;
    if (width >= 64) m = '1;
    else m = (64'd1 << width) - 64'd1;
    n = 1;
    while (m >= 64'd10) begin
      m = m / 64'd10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_step.sv
// One BCD digit of the double-dabble chain.
// Corrects a digit >= 5 by +3, then shifts it left taking carry_i as LSB.
module bcd_digit_step
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_i,
  input  logic       carry_i,
  output bcd_digit_t digit_o,
  output logic       carry_o
);

  bcd_digit_t adj;

  // add-3 correction, then one-bit shift into the next digit
  always_comb begin
    adj = digit_i;
    if (digit_i >= 4'd5) adj = digit_i + 4'd3;
    digit_o = {adj[2:0], carry_i};
    carry_o = adj[3];
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Bit-serial binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Valid/ready on both sides; optional two's-complement input.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter bit SIGNED = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                          out_neg
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;

  if (WIDTH < 2) begin : g_width_chk
    $error("bin2bcd_seq: WIDTH must be at least 2");
  end

  if (DIGITS < min_digits(WIDTH)) begin : g_digits_chk
    $error("bin2bcd_seq: DIGITS too small for WIDTH");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]   dig_q, dig_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic               valid_q, valid_d;

  logic [BCD_W-1:0]   dig_step;
  logic [DIGITS:0]    carry;

  logic               accept;
  logic               consume;
  logic               neg_in;
  logic [WIDTH-1:0]   mag_in;

  assign carry[0] = mag_q[WIDTH-1];

  for (genvar k = 0; k < DIGITS; k++) begin : g_step
    bcd_digit_step u_step (
      .digit_i (dig_q[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
      .carry_i (carry[k]),
      .digit_o (dig_step[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
      .carry_o (carry[k+1])
    );
  end

  assign in_ready = rst_n &&
                    ((state_q == IDLE) ||
                     ((state_q == DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign consume  = valid_q && out_ready;
  assign neg_in   = SIGNED && in_data[WIDTH-1];
  assign mag_in   = neg_in ? (~in_data + WIDTH'(1)) : in_data;

  // next-state: shift while busy, hold result until consumed, load on accept
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    dig_d   = dig_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: ;
      SHIFT: begin
        dig_d = dig_step;
        mag_d = mag_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          bcd_d   = dig_step;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (consume) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      mag_d   = mag_in;
      neg_d   = neg_in;
      dig_d   = '0;
      cnt_d   = CNT_W'(WIDTH - 1);
      state_d = SHIFT;
    end
  end

  // state and result registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      dig_q   <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      dig_q   <= dig_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      valid_q <= valid_d;
    end
  end

  // digits stay decimal and nothing carries out of the top digit
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == SHIFT) assert (!carry[DIGITS]);
      for (int k = 0; k < DIGITS; k++) begin
        assert (dig_q[BCD_DIGIT_W*k +: BCD_DIGIT_W] <= 4'd9);
      end
    end
  end

  assign out_valid = valid_q;
  assign out_bcd   = bcd_q;
  assign out_neg   = neg_q;

endmodule
